// File: rtl/branch_predictor_dyn_pkg.sv
// Shared definitions for the dynamic branch predictor: opcode constants
// (common with main_decoder) and the counter initial-value helper.
package branch_predictor_dyn_pkg;

    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;

    // Weakly-not-taken: MSB clear, all lower bits set.
    function automatic logic [31:0] weak_not_taken(input int unsigned width);
        return (32'd1 << (width - 1)) - 32'd1;
    endfunction

endpackage

// File: rtl/branch_predictor_dyn_sat_counter.sv
// Up/down saturating counter with enable; used for the prediction table
// entries and for the statistics counters.
module sat_counter #(
    parameter int               WIDTH     = 2,
    parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_en,
    input  logic             i_inc,
    input  logic             i_dec,
    output logic [WIDTH-1:0] o_count
);

    localparam logic [WIDTH-1:0] MAX_VAL = '1;

    logic [WIDTH-1:0] r_count;

    // Increment takes priority over decrement when both are requested.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_count <= RESET_VAL;
        end else if (i_en) begin
            if (i_inc) begin
                if (r_count != MAX_VAL) r_count <= r_count + WIDTH'(1);
            end else if (i_dec) begin
                if (r_count != '0) r_count <= r_count - WIDTH'(1);
            end
        end
    end

    assign o_count = r_count;

endmodule

// File: rtl/branch_predictor_dyn.sv
// Bimodal/gshare branch predictor: registered prediction one cycle after
// fetch, non-speculative training from execute, saturating statistics.
module branch_predictor_dyn
    import branch_predictor_dyn_pkg::*;
#(
    parameter int PC_WIDTH   = 32,
    parameter int INDEX_BITS = 6,
    parameter int CTR_BITS   = 2,
    parameter int GHR_BITS   = 0,
    parameter int STAT_BITS  = 16
) (
    input  logic                  i_clk,
    input  logic                  i_rst,
    input  logic                  i_f_valid,
    input  logic                  i_f_stall,
    input  logic [PC_WIDTH-1:0]   i_f_pc,
    input  logic [6:0]            i_f_op,
    output logic                  o_p_valid,
    output logic                  o_p_taken,
    output logic [INDEX_BITS-1:0] o_p_index,
    input  logic                  i_u_valid,
    input  logic                  i_u_is_cond,
    input  logic [INDEX_BITS-1:0] i_u_index,
    input  logic                  i_u_taken,
    input  logic                  i_u_mispredict,
    output logic [STAT_BITS-1:0]  o_br_count,
    output logic [STAT_BITS-1:0]  o_mp_count
);

    localparam int ENTRIES = 1 << INDEX_BITS;
    localparam logic [CTR_BITS-1:0] CTR_INIT = CTR_BITS'(weak_not_taken(CTR_BITS));

    logic [CTR_BITS-1:0]   w_table [ENTRIES];
    logic [INDEX_BITS-1:0] w_hist;
    logic [INDEX_BITS-1:0] w_idx;
    logic                  w_taken;
    logic                  w_upd_cond;
    logic                  w_unused_pc;

    logic                  r_p_valid;
    logic                  r_p_taken;
    logic [INDEX_BITS-1:0] r_p_index;

    assign w_upd_cond  = i_u_valid && i_u_is_cond;
    assign w_unused_pc = ^{i_f_pc[PC_WIDTH-1:INDEX_BITS+2], i_f_pc[1:0]};

    for (genvar i = 0; i < ENTRIES; i++) begin : g_table
        sat_counter #(
            .WIDTH     (CTR_BITS),
            .RESET_VAL (CTR_INIT)
        ) u_entry (
            .i_clk   (i_clk),
            .i_rst   (i_rst),
            .i_en    (w_upd_cond && (i_u_index == INDEX_BITS'(i))),
            .i_inc   (i_u_taken),
            .i_dec   (!i_u_taken),
            .o_count (w_table[i])
        );
    end

    // History only advances on resolved conditional branches.
    if (GHR_BITS > 0) begin : g_ghr
        logic [GHR_BITS-1:0] r_ghr;

        always_ff @(posedge i_clk) begin
            if (i_rst) begin
                r_ghr <= '0;
            end else if (w_upd_cond) begin
                r_ghr <= GHR_BITS'({r_ghr, i_u_taken});
            end
        end

        assign w_hist = INDEX_BITS'(r_ghr);
    end else begin : g_bimodal
        assign w_hist = '0;
    end

    assign w_idx = i_f_pc[INDEX_BITS+1:2] ^ w_hist;

    // Table read sees the pre-update counter, giving read-before-write.
    always_comb begin
        w_taken = 1'b0;
        case (i_f_op)
            OP_BRANCH:       w_taken = w_table[w_idx][CTR_BITS-1];
            OP_JAL, OP_JALR: w_taken = 1'b1;
            default:         w_taken = 1'b0;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_p_valid <= 1'b0;
            r_p_taken <= 1'b0;
            r_p_index <= '0;
        end else if (!i_f_stall) begin
            r_p_valid <= i_f_valid;
            r_p_taken <= w_taken && i_f_valid;
            r_p_index <= w_idx;
        end
    end

    assign o_p_valid = r_p_valid;
    assign o_p_taken = r_p_taken;
    assign o_p_index = r_p_index;

    sat_counter #(
        .WIDTH     (STAT_BITS),
        .RESET_VAL ('0)
    ) u_br_count (
        .i_clk   (i_clk),
        .i_rst   (i_rst),
        .i_en    (i_u_valid),
        .i_inc   (1'b1),
        .i_dec   (1'b0),
        .o_count (o_br_count)
    );

    sat_counter #(
        .WIDTH     (STAT_BITS),
        .RESET_VAL ('0)
    ) u_mp_count (
        .i_clk   (i_clk),
        .i_rst   (i_rst),
        .i_en    (i_u_valid && i_u_mispredict),
        .i_inc   (1'b1),
        .i_dec   (1'b0),
        .o_count (o_mp_count)
    );

endmodule

// File: doc/branch_predictor_dyn.md
Name: branch_predictor_dyn

Overview:
- Parametrised successor to the static, opcode-only branch predictor used beside the control unit.
- Holds a table of 2^INDEX_BITS saturating counters, indexed by PC bits, optionally XORed with a global history register (gshare).
- Produces a registered prediction one cycle after fetch and trains the table from execute-stage resolutions.
- Keeps saturating branch and mispredict statistics counters.

Parameters:
- PC_WIDTH, 32, width of fetch PC.
- INDEX_BITS, 6, table index width; 64 entries.
- CTR_BITS, 2, counter width; prediction is the counter MSB.
- GHR_BITS, 0, global history length; 0 gives pure bimodal, >0 gives gshare. Must be ≤ INDEX_BITS.
- STAT_BITS, 16, width of statistics counters.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- f_valid  in  1  fetch slot valid
- f_stall  in  1  hold prediction outputs
- f_pc  in  PC_WIDTH  fetch PC
- f_op  in  7  instruction opcode [6:0]
- p_valid  out  1  registered prediction valid
- p_taken  out  1  predicted taken
- p_index  out  INDEX_BITS  table index used; carried down the pipe for update
- u_valid  in  1  resolution valid (execute stage)
- u_is_cond  in  1  resolved instruction is a conditional branch
- u_index  in  INDEX_BITS  index returned from p_index
- u_taken  in  1  actual outcome
- u_mispredict  in  1  outcome differed from prediction
- br_count  out  STAT_BITS  resolved branches, saturating
- mp_count  out  STAT_BITS  mispredicts, saturating

Behaviour:
- All state updates on rising clk. rst is synchronous, active-high.
- Reset values:
  - Every table entry = weakly-not-taken (MSB 0, remaining bits 1; 2'b01 for CTR_BITS=2).
  - GHR = 0.
  - p_valid = 0, p_taken = 0, p_index = 0.
  - br_count = 0, mp_count = 0.
- Reset asserted mid-operation overrides any simultaneous fetch or update in that cycle.
- Index: idx = f_pc[INDEX_BITS+1:2] XOR (GHR zero-extended to INDEX_BITS). With GHR_BITS=0 the XOR term is 0.
- Decode of f_op:
  - 1100011 (branch): taken = table[idx] MSB.
  - 1101111 (JAL) and 1100111 (JALR): taken = 1.
  - Any other opcode: taken = 0.
- Latency: 1 cycle.
  - If f_stall=0, the cycle after a fetch gives p_valid = f_valid, p_taken = decoded taken & f_valid, p_index = idx.
  - If f_stall=1, all p_* outputs hold their values.
- Update: when u_valid && u_is_cond:
  - u_taken=1: table[u_index] increments, saturating at all ones.
  - u_taken=0: table[u_index] decrements, saturating at 0.
  - GHR becomes {GHR[GHR_BITS-2:0], u_taken}. History is non-speculative.
  - Updates with u_is_cond=0 (jumps) leave the table and GHR untouched.
- Read/update collision on the same index in the same cycle: the prediction uses the pre-update counter value (read-before-write). The write still occurs.
- Fetch index uses the GHR value before any update in the same cycle.
- Statistics:
  - br_count increments on u_valid.
  - mp_count increments on u_valid && u_mispredict.
  - Both saturate at 2^STAT_BITS-1 and never wrap.
- No stall input affects the update path.

Decomposition:
- Shared package holds:
  - Opcode constants OP_BRANCH=7'b1100011, OP_JAL=7'b1101111, OP_JALR=7'b1100111. These are shared with main_decoder.
  - Counter-init function for weakly-not-taken.
- One sub-module: sat_counter, parametrised by width with inc/dec/enable ports. Used for table entries and for the statistics counters.

Test Plan:
- Reset, then fetch f_op=1100011, f_pc=0x100 -> next cycle p_valid=1, p_taken=0, p_index=0x00 (0x100>>2 = 0x40, truncated to 6 bits).
- Two updates u_index=0x05, u_taken=1, then fetch a branch with f_pc=0x14 -> p_taken=1. Four more taken updates leave the counter at 2'b11; one not-taken update -> still predicts taken.
- Fetch JAL and JALR at any PC after reset -> p_taken=1. Fetch opcode 0110011 -> p_taken=0, p_valid=1.
- Same-cycle fetch and update of index 0x07 from 2'b01 with u_taken=1 -> that prediction shows 0; the following fetch of the same PC shows 1.
- GHR_BITS=2: resolve taken then taken (GHR=2'b11), then fetch f_pc=0x0 -> p_index=0x03. f_stall=1 during the next fetch -> p_* outputs unchanged.
- STAT_BITS=4: 20 mispredicting resolutions -> br_count=15, mp_count=15 (saturated). Assert rst while u_valid=1 -> counters 0 next cycle and the table is reinitialised.
